condicionador_entradas: RTL and testbench
=========================================

# condicionador_entradas

Input-conditioning stage directly upstream of the RPN calculator top level. It synchronizes and debounces the raw board buttons and switches, and turns button presses and the execute-switch edge into single, typed events. Each event carries a snapshot of the operand switches and is held under a valid/accept handshake until the calculator consumes it. It replaces direct use of raw KEY/SW levels as pseudo-clocks.

## Interface
- DEBOUNCE_CICLOS, 1000000: consecutive stable cycles required before a level change is accepted (20 ms at 50 MHz); minimum 1.
- CONT_W, 20: debounce counter width; must satisfy 2^CONT_W > DEBOUNCE_CICLOS.

- clk  input  1  system clock (CLOCK_50 domain).
- rst  input  1  reset, asynchronous, active-low.
- KEY  input  2  raw buttons, active-low (0 = pressed); KEY[0] = number entry, KEY[1] = operation entry.
- SW  input  10  raw switches; SW[7:0] = operand/op code, SW[9] = execute.
- aceito  input  1  consumer accepts the current event at this edge (sampled only while evento_valido = 1).
- evento_valido  output  1  an event is pending.
- evento_tipo  output  2  event type: 01 = number, 10 = operation, 11 = execute; 00 = none.
- evento_dado  output  8  debounced SW[7:0] captured when the event was generated; operation events use bits [2:0].
- sw_estavel  output  10  synchronized, debounced switch levels.
- evento_perdido  output  1  sticky flag: at least one event was dropped.

## Operation
- Synchronization: two-flop synchronizer on every KEY and SW bit. Reset values are KEY = 1 (released) and SW = 0.
- Debounce: applies to KEY[1:0] and each SW bit.
  - Each input has a stable level and a counter, with reset values stable KEY = 1, stable SW = 0, counter = 0.
  - If the synchronized level equals the stable level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CICLOS, the stable level takes the new value and the counter clears.
  - Glitches shorter than DEBOUNCE_CICLOS never change the stable level.
- Detection, asserted in the cycle the stable level updates:
  - number event: stable KEY[0] goes 1→0.
  - operation event: stable KEY[1] goes 1→0.
  - execute event: stable SW[9] goes 0→1.
  - Button releases and SW[9] falling edges generate nothing.
- Event FSM, states OCIOSO and VALIDO (reset: OCIOSO):
  - OCIOSO + detection: load evento_tipo, and load evento_dado from the stable SW[7:0] value after this edge's update. Go to VALIDO.
  - VALIDO + aceito = 0: hold all event outputs; any new detection is dropped and sets evento_perdido.
  - VALIDO + aceito = 1 + no detection: clear evento_tipo to 00 and go to OCIOSO.
  - VALIDO + aceito = 1 + detection: load the new event and stay in VALIDO (back-to-back, no loss).
- Simultaneous detections: priority is execute > operation > number. The winner is loaded; each loser is dropped and sets evento_perdido.
- evento_valido = (state == VALIDO).
- evento_perdido is cleared only by reset.
- SW[9] high at reset release: the stable level rises after debounce and yields one execute event. This is required behaviour.

## Timing
- Reset values (asserted immediately, asynchronously): evento_valido = 0, evento_tipo = 00, evento_dado = 0x00, sw_estavel = 0, evento_perdido = 0, FSM = OCIOSO.
- Let edge k be the first edge at which the first synchronizer flop samples the new raw level and holds it thereafter. The stable level updates at edge k+1+DEBOUNCE_CICLOS. The resulting event is visible after that same edge.
- Accept: evento_valido falls after the edge at which aceito = 1 is sampled, unless a back-to-back load occurs.
- aceito is ignored in OCIOSO.
- Reset mid-debounce or mid-handshake: the pending event and partial counts are discarded, with no output glitch after release.

## Configuration
- CONDICIONADOR_DEBOUNCE_EN defined: debounce counters present, behaviour as above.
- Not defined: counters removed and DEBOUNCE_CICLOS ignored. The stable level loads the synchronized level every cycle, so an event is visible after edge k+2. Synchronizers, edge detection, FSM and flags are unchanged.

## Test plan
All with DEBOUNCE_CICLOS = 4 and the macro defined unless stated.
- Reset check: hold rst = 0 with KEY = 2'b11 and SW = 0 -> all outputs at their reset values; no event after release.
- Number press: SW[7:0] = 0x2A, then hold KEY[0] low -> after edge k+5, evento_valido = 1, evento_tipo = 01, evento_dado = 0x2A. Assert aceito for one cycle -> evento_valido = 0 next edge. Release KEY[0] -> no event.
- Bounce rejection: KEY[1] toggles every 2 cycles for 20 cycles, then stays high -> no event, stable KEY[1] stays 1.
- Drop while pending: with an operation event pending and aceito = 0, press KEY[0] -> the event stays tipo 10, evento_perdido = 1 and stays 1 after the next accept.
- Simultaneous events: KEY[0] falls and SW[9] rises on the same edge -> tipo 11 loaded, evento_perdido = 1. Accept at the detection edge of a later press -> back-to-back load, evento_valido stays 1.
- Macro undefined: press KEY[0] -> event visible after edge k+2.

Source files
------------

// File: rtl/condicionador_entradas.sv
// Input conditioning for the RPN calculator: synchronizes and debounces KEY/SW and
// emits typed events under a valid/accept handshake. Debounce counters exist only
// when CONDICIONADOR_DEBOUNCE_EN is defined; otherwise stable levels follow the synchronizer.
module condicionador_entradas #(
    parameter int DEBOUNCE_CICLOS = 1000000,
    parameter int CONT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    input  logic       aceito,
    output logic       evento_valido,
    output logic [1:0] evento_tipo,
    output logic [7:0] evento_dado,
    output logic [9:0] sw_estavel,
    output logic       evento_perdido
);

    localparam bit PARAMS_OK = (DEBOUNCE_CICLOS >= 1) &&
                               ((64'd1 << CONT_W) > 64'(DEBOUNCE_CICLOS));

    if (!PARAMS_OK) begin : g_param_error
        $error("condicionador_entradas: need DEBOUNCE_CICLOS >= 1 and 2**CONT_W > DEBOUNCE_CICLOS");
    end

    // Channel map: [1:0] = KEY, [11:2] = SW. Buttons idle high, switches idle low.
    localparam int             N_CH    = 12;
    localparam logic [N_CH-1:0] RST_VAL = {10'b0, 2'b11};

    localparam logic [1:0] TIPO_NADA     = 2'b00;
    localparam logic [1:0] TIPO_NUMERO   = 2'b01;
    localparam logic [1:0] TIPO_OPERACAO = 2'b10;
    localparam logic [1:0] TIPO_EXECUTA  = 2'b11;

    typedef enum logic {
        OCIOSO = 1'b0,
        VALIDO = 1'b1
    } estado_t;

    logic [N_CH-1:0] raw;
    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;
    logic [N_CH-1:0] stable_q;
    logic [N_CH-1:0] stable_d;

    assign raw = {SW, KEY};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef CONDICIONADOR_DEBOUNCE_EN
    // The counter reaching DEBOUNCE_CICLOS is detected one step early so the
    // level update lands on the same edge as the final increment.
    localparam logic [CONT_W-1:0] CNT_MAX = CONT_W'(DEBOUNCE_CICLOS - 1);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_canal
            logic stb_q;
            logic stb_d;
`ifdef CONDICIONADOR_DEBOUNCE_EN
            logic [CONT_W-1:0] cnt_q;
            logic [CONT_W-1:0] cnt_d;

            always_comb begin
                cnt_d = '0;
                stb_d = stb_q;
                if (sync2_q[gi] != stb_q) begin
                    if (cnt_q == CNT_MAX) begin
                        stb_d = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                    stb_q <= RST_VAL[gi];
                end else begin
                    cnt_q <= cnt_d;
                    stb_q <= stb_d;
                end
            end
`else
            assign stb_d = sync2_q[gi];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stb_q <= RST_VAL[gi];
                end else begin
                    stb_q <= stb_d;
                end
            end
`endif
            assign stable_q[gi] = stb_q;
            assign stable_d[gi] = stb_d;
        end
    endgenerate

    // Edges are taken between the current and next stable level, so the event
    // is loaded on the very edge at which the stable level changes.
    logic det_num;
    logic det_op;
    logic det_exe;
    logic any_det;
    logic multi_det;
    logic [1:0] tipo_win;

    assign det_num   =  stable_q[0]  & ~stable_d[0];
    assign det_op    =  stable_q[1]  & ~stable_d[1];
    assign det_exe   = ~stable_q[11] &  stable_d[11];
    assign any_det   = det_num | det_op | det_exe;
    assign multi_det = (det_exe & det_op) | (det_exe & det_num) | (det_op & det_num);

    always_comb begin
        tipo_win = TIPO_NADA;
        if (det_exe) begin
            tipo_win = TIPO_EXECUTA;
        end else if (det_op) begin
            tipo_win = TIPO_OPERACAO;
        end else if (det_num) begin
            tipo_win = TIPO_NUMERO;
        end
    end

    estado_t    estado_q;
    logic [1:0] tipo_q;
    logic [7:0] dado_q;
    logic       perdido_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q  <= OCIOSO;
            tipo_q    <= TIPO_NADA;
            dado_q    <= 8'h00;
            perdido_q <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (any_det) begin
                        tipo_q   <= tipo_win;
                        dado_q   <= stable_d[9:2];
                        estado_q <= VALIDO;
                        if (multi_det) begin
                            perdido_q <= 1'b1;
                        end
                    end
                end
                VALIDO: begin
                    if (!aceito) begin
                        if (any_det) begin
                            perdido_q <= 1'b1;
                        end
                    end else if (any_det) begin
                        tipo_q <= tipo_win;
                        dado_q <= stable_d[9:2];
                        if (multi_det) begin
                            perdido_q <= 1'b1;
                        end
                    end else begin
                        tipo_q   <= TIPO_NADA;
                        estado_q <= OCIOSO;
                    end
                end
                default: begin
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign evento_valido  = (estado_q == VALIDO);
    assign evento_tipo    = tipo_q;
    assign evento_dado    = dado_q;
    assign evento_perdido = perdido_q;
    assign sw_estavel     = stable_q[11:2];

endmodule

// File: tb/tb_condicionador_entradas.sv
// Directed bench for condicionador_entradas with DEBOUNCE_CICLOS = 4; expected event
// latency follows CONDICIONADOR_DEBOUNCE_EN (k+1+D when defined, k+2 otherwise).
module tb_condicionador_entradas;

    localparam int D = 4;
`ifdef CONDICIONADOR_DEBOUNCE_EN
    localparam int LAT = D + 1;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] KEY = 2'b11;
    logic [9:0] SW  = 10'h000;
    logic       aceito = 1'b0;
    logic       evento_valido;
    logic [1:0] evento_tipo;
    logic [7:0] evento_dado;
    logic [9:0] sw_estavel;
    logic       evento_perdido;

    int n_tests = 0;
    int n_fail  = 0;

    condicionador_entradas #(
        .DEBOUNCE_CICLOS(D),
        .CONT_W         (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .KEY           (KEY),
        .SW            (SW),
        .aceito        (aceito),
        .evento_valido (evento_valido),
        .evento_tipo   (evento_tipo),
        .evento_dado   (evento_dado),
        .sw_estavel    (sw_estavel),
        .evento_perdido(evento_perdido)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held low with buttons released and switches low.
        tick(3);
        check("rst_valido",  32'(evento_valido),  32'h0);
        check("rst_tipo",    32'(evento_tipo),    32'h0);
        check("rst_dado",    32'(evento_dado),    32'h00);
        check("rst_sw",      32'(sw_estavel),     32'h000);
        check("rst_perdido", 32'(evento_perdido), 32'h0);
        rst = 1'b1;
        tick(10);
        check("pos_rst_sem_evento", 32'(evento_valido), 32'h0);
        $display("[TB] reset: done");

        // Number press with operand 0x2A.
        SW = 10'h02A;
        tick(LAT + 2);
        check("sw_estavel_2a", 32'(sw_estavel), 32'h02A);
        KEY = 2'b10;
        tick(LAT);
        check("num_antes_latencia", 32'(evento_valido), 32'h0);
        tick(1);
        check("num_valido", 32'(evento_valido), 32'h1);
        check("num_tipo",   32'(evento_tipo),   32'h1);
        check("num_dado",   32'(evento_dado),   32'h2A);
        aceito = 1'b1;
        tick(1);
        aceito = 1'b0;
        check("num_aceito_valido", 32'(evento_valido), 32'h0);
        check("num_aceito_tipo",   32'(evento_tipo),   32'h0);
        KEY = 2'b11;
        tick(LAT + 3);
        check("num_soltar_sem_evento", 32'(evento_valido), 32'h0);
        $display("[TB] number press: done");

`ifdef CONDICIONADOR_DEBOUNCE_EN
        // Bounce shorter than the debounce window must never produce an event.
        for (int i = 0; i < 10; i++) begin
            KEY[1] = ~KEY[1];
            tick(2);
            check("bounce_sem_evento", 32'(evento_valido), 32'h0);
        end
        tick(8);
        check("bounce_final_valido",  32'(evento_valido),  32'h0);
        check("bounce_final_perdido", 32'(evento_perdido), 32'h0);
        $display("[TB] bounce rejection: done");
`endif

        // Operation pending, then a number press is dropped.
        KEY = 2'b01;
        tick(LAT + 1);
        check("op_valido", 32'(evento_valido), 32'h1);
        check("op_tipo",   32'(evento_tipo),   32'h2);
        check("op_dado",   32'(evento_dado),   32'h2A);
        KEY = 2'b00;
        tick(LAT + 1);
        check("drop_valido",  32'(evento_valido),  32'h1);
        check("drop_tipo",    32'(evento_tipo),    32'h2);
        check("drop_perdido", 32'(evento_perdido), 32'h1);
        aceito = 1'b1;
        tick(1);
        aceito = 1'b0;
        check("drop_aceito_valido",  32'(evento_valido),  32'h0);
        check("drop_aceito_perdido", 32'(evento_perdido), 32'h1);
        KEY = 2'b11;
        tick(LAT + 3);
        check("drop_soltar_sem_evento", 32'(evento_valido), 32'h0);
        $display("[TB] drop while pending: done");

        // Reset clears the sticky flag.
        rst = 1'b0;
        tick(2);
        check("rst2_perdido", 32'(evento_perdido), 32'h0);
        check("rst2_sw",      32'(sw_estavel),     32'h000);
        rst = 1'b1;
        tick(LAT + 3);
        check("rst2_sw_volta", 32'(sw_estavel),    32'h02A);
        check("rst2_sem_evento", 32'(evento_valido), 32'h0);

        // KEY[0] falls and SW[9] rises together: execute wins, number dropped.
        KEY = 2'b10;
        SW  = 10'h22A;
        tick(LAT + 1);
        check("simul_valido",  32'(evento_valido),  32'h1);
        check("simul_tipo",    32'(evento_tipo),    32'h3);
        check("simul_dado",    32'(evento_dado),    32'h2A);
        check("simul_perdido", 32'(evento_perdido), 32'h1);

        // Accept exactly on the detection edge of an operation press.
        KEY = 2'b00;
        tick(LAT);
        check("b2b_antes_tipo", 32'(evento_tipo), 32'h3);
        aceito = 1'b1;
        tick(1);
        aceito = 1'b0;
        check("b2b_valido", 32'(evento_valido), 32'h1);
        check("b2b_tipo",   32'(evento_tipo),   32'h2);
        tick(1);
        check("b2b_mantem_tipo", 32'(evento_tipo), 32'h2);
        aceito = 1'b1;
        tick(1);
        aceito = 1'b0;
        check("b2b_aceito_valido", 32'(evento_valido), 32'h0);
        $display("[TB] simultaneous and back-to-back: done");

        // SW[9] already high at reset release yields exactly one execute event.
        KEY = 2'b11;
        tick(LAT + 3);
        rst = 1'b0;
        tick(2);
        check("rst3_valido", 32'(evento_valido), 32'h0);
        rst = 1'b1;
        tick(LAT);
        check("sw9_antes_latencia", 32'(evento_valido), 32'h0);
        tick(1);
        check("sw9_valido",  32'(evento_valido),  32'h1);
        check("sw9_tipo",    32'(evento_tipo),    32'h3);
        check("sw9_dado",    32'(evento_dado),    32'h2A);
        check("sw9_perdido", 32'(evento_perdido), 32'h0);
        aceito = 1'b1;
        tick(1);
        aceito = 1'b0;
        tick(LAT + 3);
        check("sw9_um_evento", 32'(evento_valido), 32'h0);
        check("sw9_sw_estavel", 32'(sw_estavel),   32'h22A);
        $display("[TB] SW[9] high at reset release: done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
